// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller in front of a dual-port RAM with 1-cycle registered read.
// Define FIFO_LEVEL_EN to add the registered LEVEL and ALMOST_FULL outputs.
module dpram_fifo_ctrl #(
   parameter int unsigned DATAWL = 8,
   parameter int unsigned ADDRWL = 8
`ifdef FIFO_LEVEL_EN
   ,
   parameter int unsigned AFULL_TH = (1 << ADDRWL) - 4
`endif
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CLR,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATAWL-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATAWL-1:0] OUT_DATA,
   output logic              RAM_WE,
   output logic [ADDRWL-1:0] RAM_WA,
   output logic [DATAWL-1:0] RAM_WD,
   output logic [ADDRWL-1:0] RAM_RA,
   input  logic [DATAWL-1:0] RAM_RD
`ifdef FIFO_LEVEL_EN
   ,
   output logic [ADDRWL+1:0] LEVEL,
   output logic              ALMOST_FULL
`endif
);

   localparam logic [ADDRWL:0] FULL_CNT = {1'b1, {ADDRWL{1'b0}}};

   logic [ADDRWL-1:0] wptr_q, wptr_d;
   logic [ADDRWL-1:0] rptr_q, rptr_d;
   logic [ADDRWL:0]   mem_cnt_q, mem_cnt_d;
   logic              pend_q, pend_d;
   logic [1:0]        stage_cnt_q, stage_cnt_d;
   logic [DATAWL-1:0] out_q, out_d;
   logic [DATAWL-1:0] skid_q, skid_d;

   logic       push, pop, issue;
   logic [2:0] occ_after_pop;
   logic [1:0] stage_after_pop;

   assign IN_READY  = (mem_cnt_q != FULL_CNT) & ~CLR;
   assign OUT_VALID = (stage_cnt_q != 2'd0);
   assign OUT_DATA  = out_q;

   // RSTN gate keeps the RAM write port quiet while the controller is held in reset.
   assign push   = IN_VALID & IN_READY & RSTN;
   assign pop    = OUT_VALID & OUT_READY;
   assign RAM_WE = push;
   assign RAM_WA = wptr_q;
   assign RAM_WD = IN_DATA;
   assign RAM_RA = rptr_q;

   assign stage_after_pop = stage_cnt_q - {1'b0, pop};
   assign occ_after_pop   = {1'b0, stage_after_pop} + {2'b00, pend_q};
   // Only issue when the word returning next cycle is guaranteed a stage slot.
   assign issue = (mem_cnt_q != '0) & (occ_after_pop < 3'd2);

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      mem_cnt_d   = mem_cnt_q;
      pend_d      = issue;
      stage_cnt_d = stage_after_pop + {1'b0, pend_q};
      out_d       = out_q;
      skid_d      = skid_q;

      if (push) wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;

      unique case ({push, issue})
         2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
         2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
         default: mem_cnt_d = mem_cnt_q;
      endcase

      if (pop && stage_cnt_q == 2'd2) out_d = skid_q;
      if (pend_q) begin
         if (stage_after_pop == 2'd0) out_d = RAM_RD;
         else skid_d = RAM_RD;
      end

      if (CLR) begin
         wptr_d      = '0;
         rptr_d      = '0;
         mem_cnt_d   = '0;
         pend_d      = 1'b0;
         stage_cnt_d = '0;
         out_d       = '0;
         skid_d      = '0;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         mem_cnt_q   <= '0;
         pend_q      <= 1'b0;
         stage_cnt_q <= '0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         mem_cnt_q   <= mem_cnt_d;
         pend_q      <= pend_d;
         stage_cnt_q <= stage_cnt_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
      end
   end

`ifdef FIFO_LEVEL_EN
   localparam logic [ADDRWL:0] AFULL_CNT = AFULL_TH[ADDRWL:0];

   logic [ADDRWL+1:0] level_q, level_d;
   logic              afull_q, afull_d;

   // Built from next-state values so LEVEL matches the occupancy after each edge.
   assign level_d = (ADDRWL+2)'(mem_cnt_d) + (ADDRWL+2)'(pend_d) + (ADDRWL+2)'(stage_cnt_d);
   assign afull_d = (mem_cnt_d >= AFULL_CNT);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         level_q <= '0;
         afull_q <= 1'b0;
      end else begin
         level_q <= level_d;
         afull_q <= afull_d;
      end
   end

   assign LEVEL       = level_q;
   assign ALMOST_FULL = afull_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 1-cycle-latency RAM (ADDRWL = 4).
module tb_dpram_fifo_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          CLK = 1'b0;
   logic          RSTN, CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY, RAM_WE;
   logic [DW-1:0] IN_DATA, OUT_DATA, RAM_WD, RAM_RD;
   logic [AW-1:0] RAM_WA, RAM_RA;
`ifdef FIFO_LEVEL_EN
   logic [AW+1:0] LEVEL;
   logic          ALMOST_FULL;
`endif

   int n_cmp = 0;
   int n_err = 0;

   dpram_fifo_ctrl #(.DATAWL(DW), .ADDRWL(AW)) dut (
      .CLK(CLK), .RSTN(RSTN), .CLR(CLR),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .RAM_WE(RAM_WE), .RAM_WA(RAM_WA), .RAM_WD(RAM_WD), .RAM_RA(RAM_RA), .RAM_RD(RAM_RD)
`ifdef FIFO_LEVEL_EN
      , .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL)
`endif
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] ram [1 << AW];
   always @(posedge CLK) begin
      if (RAM_WE) ram[RAM_WA] <= RAM_WD;
      RAM_RD <= ram[RAM_RA];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer words base, base+1, ... until n are accepted or the cycle budget runs out.
   task automatic fill(input int n, input int base, output int acc);
      bit take;
      acc = 0;
      IN_VALID = 1'b1;
      IN_DATA = 8'(base);
      for (int c = 0; c < n + 40 && acc < n; c++) begin
         @(negedge CLK);
         take = IN_READY;
         @(posedge CLK); #1;
         if (take) begin
            acc++;
            IN_DATA = 8'(base + acc);
         end
      end
      IN_VALID = 1'b0;
   endtask

   int            acc, sent, rcvd, bubbles, first_c;
   bit            do_push, hold;
   logic [DW-1:0] held, expd;
   logic [DW-1:0] q[$];

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      RSTN = 1'b0; CLR = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'h3C; OUT_READY = 1'b0;

      // Reset values, with IN_VALID high to confirm the write port stays quiet
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_in_ready", IN_READY, 1);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_out_data", OUT_DATA, 0);
      check("rst_ram_we", RAM_WE, 0);
      check("rst_ram_ra", RAM_RA, 0);
`ifdef FIFO_LEVEL_EN
      check("rst_level", LEVEL, 0);
`endif
      @(posedge CLK); #1;
      RSTN = 1'b1; IN_VALID = 1'b0;
      @(posedge CLK); #1;

      // Single word latency
      IN_VALID = 1'b1; IN_DATA = 8'h11; OUT_READY = 1'b1;
      @(negedge CLK);
      check("t1_ram_we", RAM_WE, 1);
      check("t1_ram_wa", RAM_WA, 0);
      check("t1_ram_wd", RAM_WD, 8'h11);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      check("t1_valid_n1", OUT_VALID, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("t1_valid_n2", OUT_VALID, 0);
      check("t1_ram_ra", RAM_RA, 1);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("t1_valid_n3", OUT_VALID, 1);
      check("t1_data", OUT_DATA, 8'h11);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("t1_empty", OUT_VALID, 0);
      check("t1_data_hold", OUT_DATA, 8'h11);

      // Fill against a stalled consumer: 16 RAM + 2 stage words
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      fill(21, 0, acc);
      check("t2_accepted", acc, 18);
      @(negedge CLK);
      check("t2_in_ready", IN_READY, 0);
      check("t2_head", OUT_DATA, 8'h00);
`ifdef FIFO_LEVEL_EN
      check("t2_level", LEVEL, 18);
      check("t2_afull", ALMOST_FULL, 1);
`endif
      @(posedge CLK); #1;
      OUT_READY = 1'b1;
      rcvd = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK);
         if (OUT_VALID) begin
            check("t2_data", OUT_DATA, 8'(rcvd));
            rcvd++;
         end
         @(posedge CLK); #1;
      end
      check("t2_popped", rcvd, 18);
      check("t2_drained", OUT_VALID, 0);

      // Full FIFO: push rejected in the pop cycle, accepted next; then CLR
      OUT_READY = 1'b0;
      fill(18, 8'h20, acc);
      check("t6_accepted", acc, 18);
      IN_VALID = 1'b1; IN_DATA = 8'h77; OUT_READY = 1'b1;
      @(negedge CLK);
      check("t6_full_ready", IN_READY, 0);
      check("t6_full_we", RAM_WE, 0);
      check("t6_head", OUT_DATA, 8'h20);
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      @(negedge CLK);
      check("t6_next_ready", IN_READY, 1);
      check("t6_next_we", RAM_WE, 1);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
`ifdef FIFO_LEVEL_EN
      @(negedge CLK);
      check("t6_level", LEVEL, 18);
      @(posedge CLK); #1;
`endif
      CLR = 1'b1;
      @(negedge CLK);
      check("t6_clr_ready", IN_READY, 0);
      @(posedge CLK); #1;
      CLR = 1'b0;
      @(negedge CLK);
      check("t6_clr_valid", OUT_VALID, 0);
      check("t6_clr_ready_after", IN_READY, 1);
      check("t6_clr_ra", RAM_RA, 0);
      check("t6_clr_data", OUT_DATA, 0);
`ifdef FIFO_LEVEL_EN
      check("t6_clr_level", LEVEL, 0);
`endif

      // Continuous streaming of 100 words
      @(posedge CLK); #1;
      sent = 0; rcvd = 0; bubbles = 0; first_c = -1;
      IN_VALID = 1'b1; IN_DATA = 8'h00; OUT_READY = 1'b1;
      for (int c = 0; c < 300 && rcvd < 100; c++) begin
         @(negedge CLK);
         if (OUT_VALID) begin
            if (first_c < 0) first_c = c;
            check("t3_data", OUT_DATA, 8'(rcvd));
            rcvd++;
         end else if (rcvd > 0) begin
            bubbles++;
         end
         do_push = IN_VALID && IN_READY;
         @(posedge CLK); #1;
         if (do_push) begin
            sent++;
            IN_DATA = 8'(sent);
            if (sent == 100) IN_VALID = 1'b0;
         end
      end
      check("t3_count", rcvd, 100);
      check("t3_first", first_c, 3);
      check("t3_bubbles", bubbles, 0);

      // Random handshakes, scoreboard and hold stability
      q.delete();
      sent = 0; rcvd = 0; hold = 1'b0; held = '0;
      IN_VALID = 1'($urandom_range(0, 1)); IN_DATA = 8'($urandom);
      OUT_READY = 1'($urandom_range(0, 1));
      for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
         @(negedge CLK);
         if (hold) begin
            check("t4_hold_valid", OUT_VALID, 1);
            check("t4_hold_data", OUT_DATA, held);
         end
         hold = OUT_VALID && !OUT_READY;
         held = OUT_DATA;
         if (OUT_VALID && OUT_READY) begin
            check("t4_nonempty", (q.size() != 0), 1);
            if (q.size() != 0) begin
               expd = q.pop_front();
               check("t4_data", OUT_DATA, expd);
            end
            rcvd++;
         end
         if (IN_VALID && IN_READY) begin
            q.push_back(IN_DATA);
            sent++;
         end
         @(posedge CLK); #1;
         IN_VALID = (sent < 1000) && ($urandom_range(0, 1) == 1);
         IN_DATA = 8'($urandom);
         OUT_READY = ($urandom_range(0, 1) == 1);
      end
      check("t4_count", rcvd, 1000);
      IN_VALID = 1'b0;

      // Asynchronous reset in the middle of a burst
      OUT_READY = 1'b0;
      fill(10, 8'h40, acc);
      check("t5_accepted", acc, 10);
      RSTN = 1'b0;
      @(negedge CLK);
      check("t5_rst_valid", OUT_VALID, 0);
      check("t5_rst_ready", IN_READY, 1);
`ifdef FIFO_LEVEL_EN
      check("t5_rst_level", LEVEL, 0);
`endif
      @(posedge CLK); #1;
      RSTN = 1'b1;
      IN_VALID = 1'b1; IN_DATA = 8'hA5; OUT_READY = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         if (OUT_VALID) break;
      end
      check("t5_valid", OUT_VALID, 1);
      check("t5_data", OUT_DATA, 8'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
